// File: rtl/spi_flash_slave.sv
// -----------------------------------------------------------------------------
// spi_flash_slave
// SPI mode-0 flash responder. Oversamples the SPI pins on pclk, decodes
// FAST_READ (0x0B) and READ JEDEC ID (0x9F), and streams read data fetched
// one 32-bit word at a time through a req/ack memory port (current word plus
// one prefetch word).
//
// Ports
//   pclk       system clock, all SPI pins are oversampled on it
//   presetn    asynchronous active-low reset
//   spi_clk    SPI clock from the master (CPOL=0)
//   spi_cs     chip select, active low
//   spi_mosi   master-out serial data
//   spi_miso   slave-out serial data (registered)
//   mem_req    word fetch request, held until mem_ack
//   mem_addr   word address = byte address[23:2]
//   mem_ack    one-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata  fetched word, little-endian byte lanes
//   underrun   one-cycle pulse when a data byte starts without its word
// -----------------------------------------------------------------------------
module spi_flash_slave #(
   parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        spi_clk,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        mem_req,
   output logic [21:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        underrun
);

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned WADR_W = 22;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 5;

   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] CMD_JEDEC_ID  = 8'h9F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_ID,
      S_IGNORE
   } state_e;

   // ---------------------------------------------------------------------
   // Pin synchronisers; the third SCK stage gives edge detection
   // ---------------------------------------------------------------------
   logic sck_s1_q, sck_s2_q, sck_s3_q;
   logic cs_s1_q, cs_s2_q;
   logic mosi_s1_q, mosi_s2_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sck_s1_q  <= 1'b0;
         sck_s2_q  <= 1'b0;
         sck_s3_q  <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         sck_s1_q  <= spi_clk;
         sck_s2_q  <= sck_s1_q;
         sck_s3_q  <= sck_s2_q;
         cs_s1_q   <= spi_cs;
         cs_s2_q   <= cs_s1_q;
         mosi_s1_q <= spi_mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   logic sck_rise_c, sck_fall_c, cs_off_c;
   assign sck_rise_c = sck_s2_q & ~sck_s3_q;
   assign sck_fall_c = ~sck_s2_q & sck_s3_q;
   assign cs_off_c   = cs_s2_q;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [6:0]          cmd_q, cmd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;       // byte address; JEDEC shifter in S_ID
   logic [7:0]          byte_q, byte_d;
   logic [DATA_W-1:0]   cur_word_q, cur_word_d;
   logic                cur_vld_q, cur_vld_d;
   logic [DATA_W-1:0]   pre_word_q, pre_word_d;
   logic                pre_vld_q, pre_vld_d;
   logic                fetch_pend_q, fetch_pend_d;
   logic [WADR_W-1:0]   fetch_addr_q, fetch_addr_d;
   logic                discard_q, discard_d;
   logic                miso_q, miso_d;
   logic                req_q, req_d;
   logic [WADR_W-1:0]   req_addr_q, req_addr_d;
   logic                underrun_q, underrun_d;

   logic [7:0]          cmd_next_c;
   logic [ADDR_W-1:0]   addr_next_c;
   logic [7:0]          lane_byte_c;
   logic                new_fetch_c;
   logic [WADR_W-1:0]   new_waddr_c;

   assign cmd_next_c  = {cmd_q, mosi_s2_q};
   assign addr_next_c = {addr_q[ADDR_W-2:0], mosi_s2_q};

   // Byte of the current word selected by the address lane
   always_comb begin
      lane_byte_c = cur_word_q[7:0];
      case (addr_q[1:0])
         2'd0:    lane_byte_c = cur_word_q[7:0];
         2'd1:    lane_byte_c = cur_word_q[15:8];
         2'd2:    lane_byte_c = cur_word_q[23:16];
         default: lane_byte_c = cur_word_q[31:24];
      endcase
   end

   // FSM state register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Datapath registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         bitcnt_q     <= '0;
         cmd_q        <= '0;
         addr_q       <= '0;
         byte_q       <= '0;
         cur_word_q   <= '0;
         cur_vld_q    <= 1'b0;
         pre_word_q   <= '0;
         pre_vld_q    <= 1'b0;
         fetch_pend_q <= 1'b0;
         fetch_addr_q <= '0;
         discard_q    <= 1'b0;
         miso_q       <= 1'b0;
         req_q        <= 1'b0;
         req_addr_q   <= '0;
         underrun_q   <= 1'b0;
      end else begin
         bitcnt_q     <= bitcnt_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         byte_q       <= byte_d;
         cur_word_q   <= cur_word_d;
         cur_vld_q    <= cur_vld_d;
         pre_word_q   <= pre_word_d;
         pre_vld_q    <= pre_vld_d;
         fetch_pend_q <= fetch_pend_d;
         fetch_addr_q <= fetch_addr_d;
         discard_q    <= discard_d;
         miso_q       <= miso_d;
         req_q        <= req_d;
         req_addr_q   <= req_addr_d;
         underrun_q   <= underrun_d;
      end
   end

   // Next-state, serial datapath, word buffer and memory handshake
   always_comb begin
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      byte_d       = byte_q;
      cur_word_d   = cur_word_q;
      cur_vld_d    = cur_vld_q;
      pre_word_d   = pre_word_q;
      pre_vld_d    = pre_vld_q;
      fetch_pend_d = fetch_pend_q;
      fetch_addr_d = fetch_addr_q;
      discard_d    = discard_q;
      miso_d       = miso_q;
      req_d        = req_q;
      req_addr_d   = req_addr_q;
      underrun_d   = 1'b0;
      new_fetch_c  = 1'b0;
      new_waddr_c  = '0;

      if (cs_off_c) begin
         // Deselect wins over any coincident SCK edge; a request still in
         // flight is allowed to finish but its data is dropped.
         state_d      = S_IDLE;
         bitcnt_d     = '0;
         miso_d       = 1'b0;
         cur_vld_d    = 1'b0;
         pre_vld_d    = 1'b0;
         fetch_pend_d = 1'b0;
         if (req_q && !mem_ack) discard_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               // CS reads high in every cycle of IDLE except the first
               // one after its falling edge.
               state_d  = S_CMD;
               bitcnt_d = '0;
               miso_d   = 1'b0;
            end

            S_CMD: begin
               if (sck_rise_c) begin
                  cmd_d    = cmd_next_c[6:0];
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  if (bitcnt_q == CNT_W'(7)) begin
                     bitcnt_d = '0;
                     case (cmd_next_c)
                        CMD_FAST_READ: state_d = S_ADDR;
                        CMD_JEDEC_ID: begin
                           state_d = S_ID;
                           addr_d  = JEDEC_ID;
                        end
                        default:       state_d = S_IGNORE;
                     endcase
                  end
               end
            end

            S_ADDR: begin
               if (sck_rise_c) begin
                  addr_d   = addr_next_c;
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  if (bitcnt_q == CNT_W'(23)) begin
                     bitcnt_d    = '0;
                     state_d     = S_DUMMY;
                     cur_vld_d   = 1'b0;
                     pre_vld_d   = 1'b0;
                     new_fetch_c = 1'b1;
                     new_waddr_c = addr_next_c[ADDR_W-1:2];
                  end
               end
            end

            S_DUMMY: begin
               miso_d = 1'b0;
               if (sck_rise_c) begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  if (bitcnt_q == CNT_W'(7)) begin
                     bitcnt_d = '0;
                     state_d  = S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (sck_fall_c) begin
                  if (bitcnt_q[2:0] == 3'd0) begin
                     // Byte start: load from the current word or flag underrun
                     if (cur_vld_q) begin
                        miso_d = lane_byte_c[7];
                        byte_d = {lane_byte_c[6:0], 1'b0};
                     end else begin
                        miso_d     = 1'b1;
                        byte_d     = 8'hFE;
                        underrun_d = 1'b1;
                     end
                     if (addr_q[1:0] == 2'd3) begin
                        new_fetch_c = 1'b1;
                        new_waddr_c = addr_q[ADDR_W-1:2] + WADR_W'(1);
                     end
                  end else begin
                     miso_d = byte_q[7];
                     byte_d = {byte_q[6:0], 1'b0};
                  end
               end else if (sck_rise_c) begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  if (bitcnt_q[2:0] == 3'd7) begin
                     bitcnt_d = '0;
                     addr_d   = addr_q + ADDR_W'(1);
                     // Crossing into lane 0: prefetch becomes current
                     if (addr_q[1:0] == 2'd3) begin
                        cur_word_d = pre_word_q;
                        cur_vld_d  = pre_vld_q;
                        pre_vld_d  = 1'b0;
                     end
                  end
               end
            end

            S_ID: begin
               // addr_q holds the ID; zeros shift in behind it
               if (sck_fall_c) begin
                  miso_d = addr_q[ADDR_W-1];
                  addr_d = {addr_q[ADDR_W-2:0], 1'b0};
               end
            end

            S_IGNORE: miso_d = 1'b0;

            default: state_d = S_IDLE;
         endcase
      end

      // Returned word fills the current slot first, otherwise the prefetch
      if (req_q && mem_ack) begin
         req_d     = 1'b0;
         discard_d = 1'b0;
         if (!discard_q && !cs_off_c) begin
            if (!cur_vld_d) begin
               cur_word_d = mem_rdata;
               cur_vld_d  = 1'b1;
            end else begin
               pre_word_d = mem_rdata;
               pre_vld_d  = 1'b1;
            end
         end
      end

      // Fetch launch; waits while another request is outstanding
      if (new_fetch_c) begin
         fetch_pend_d = 1'b1;
         fetch_addr_d = new_waddr_c;
      end
      if (fetch_pend_d && !req_q) begin
         req_d        = 1'b1;
         req_addr_d   = fetch_addr_d;
         fetch_pend_d = 1'b0;
      end
   end

   assign spi_miso = miso_q;
   assign mem_req  = req_q;
   assign mem_addr = req_addr_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_flash_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_slave
// Drives spi_flash_slave as an SPI mode-0 master with a behavioural memory
// responder; expected bytes and fetch addresses come from a byte-level model.
// -----------------------------------------------------------------------------
module tb_spi_flash_slave;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        spi_clk, spi_cs, spi_mosi, spi_miso;
   logic        mem_req, mem_ack, underrun;
   logic [21:0] mem_addr;
   logic [31:0] mem_rdata;

   always #5 pclk = ~pclk;

   spi_flash_slave #(.JEDEC_ID(24'hEF4018)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .spi_clk   (spi_clk),
      .spi_cs    (spi_cs),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .underrun  (underrun)
   );

   localparam logic [31:0] ID_STREAM = {24'hEF4018, 8'h00};

   int n_vec = 0;
   int n_err = 0;
   int half_p = 4;
   int ack_delay = 2;
   int next_delay = -1;
   int resp_dly;
   int und_cnt = 0;
   int ack_cnt = 0;
   int hold_err = 0;
   int drop_err = 0;
   logic resp_busy = 1'b0;
   logic [21:0] resp_addr;
   logic [21:0] addr_log[$];
   logic [31:0] mem_aa [logic [21:0]];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [21:0] a);
      if (mem_aa.exists(a)) return mem_aa[a];
      return {a[9:0], a} ^ 32'hA5C3_5A3C;
   endfunction

   function automatic logic [7:0] model_byte(input logic [23:0] ba);
      logic [31:0] w;
      w = mem_word(ba[23:2]);
      return w[int'(ba[1:0]) * 8 +: 8];
   endfunction

   // Memory responder: one request at a time, ack after a programmable delay
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge pclk);
         if (presetn === 1'b1 && mem_req === 1'b1) begin
            resp_busy = 1'b1;
            resp_addr = mem_addr;
            addr_log.push_back(resp_addr);
            resp_dly = (next_delay >= 0) ? next_delay : ack_delay;
            next_delay = -1;
            repeat (resp_dly) begin
               @(negedge pclk);
               if (mem_req !== 1'b1 || mem_addr !== resp_addr) hold_err++;
            end
            mem_ack = 1'b1;
            mem_rdata = mem_word(resp_addr);
            ack_cnt++;
            @(negedge pclk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (mem_req !== 1'b0) drop_err++;
            resp_busy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge pclk);
         if (underrun === 1'b1) und_cnt++;
      end
   end

   task automatic spi_bit(input logic b, output logic r);
      spi_mosi = b;
      repeat (half_p) @(negedge pclk);
      r = spi_miso;
      spi_clk = 1'b1;
      repeat (half_p) @(negedge pclk);
      spi_clk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] o, output logic [7:0] r);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(o[i], b);
         r[i] = b;
      end
   endtask

   task automatic cs_begin();
      spi_cs = 1'b0;
      repeat (4) @(negedge pclk);
   endtask

   task automatic wait_mem_idle(input string tag);
      int n;
      n = 0;
      while ((mem_req === 1'b1 || resp_busy) && n < 2000) begin
         @(negedge pclk);
         n++;
      end
      check_val(tag, 32'(n >= 2000), 32'd0);
   endtask

   task automatic cs_end(input string tag);
      repeat (half_p) @(negedge pclk);
      spi_cs = 1'b1;
      repeat (6) @(negedge pclk);
      wait_mem_idle({tag, "_mem_idle"});
      repeat (4) @(negedge pclk);
   endtask

   task automatic do_jedec(input string tag);
      logic [7:0] r;
      cs_begin();
      spi_byte(8'h9F, r);
      check_val({tag, "_cmd_miso"}, 32'(r), 32'd0);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'($urandom), r);
         check_val($sformatf("%s_id%0d", tag, i), 32'(r), 32'(ID_STREAM[31 - 8*i -: 8]));
      end
      cs_end(tag);
   endtask

   task automatic do_read(input logic [23:0] a, input int n, input int exp_und, input string tag);
      logic [7:0] r;
      logic [23:0] ba;
      logic [21:0] exp_log[$];
      int und0;
      addr_log.delete();
      und0 = und_cnt;
      exp_log.push_back(a[23:2]);
      cs_begin();
      spi_byte(8'h0B, r);
      spi_byte(a[23:16], r);
      spi_byte(a[15:8], r);
      spi_byte(a[7:0], r);
      spi_byte(8'h00, r);
      check_val({tag, "_dummy"}, 32'(r), 32'd0);
      for (int i = 0; i < n; i++) begin
         ba = a + 24'(i);
         spi_byte(8'($urandom), r);
         check_val($sformatf("%s_byte%0d", tag, i), 32'(r),
                   (exp_und != 0 && i == 0) ? 32'h0000_00FF : 32'(model_byte(ba)));
         if (ba[1:0] == 2'd3) exp_log.push_back(ba[23:2] + 22'd1);
      end
      cs_end(tag);
      check_val({tag, "_nreq"}, 32'(addr_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < addr_log.size(); i++)
         check_val($sformatf("%s_addr%0d", tag, i), 32'(addr_log[i]), 32'(exp_log[i]));
      check_val({tag, "_underrun"}, 32'(und_cnt - und0), 32'(exp_und));
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      logic b;
      int a0;
      int kind;
      logic [7:0] cmd;

      presetn  = 1'b0;
      spi_clk  = 1'b0;
      spi_cs   = 1'b1;
      spi_mosi = 1'b0;
      repeat (5) @(negedge pclk);
      check_val("rst_miso", 32'(spi_miso), 32'd0);
      check_val("rst_req", 32'(mem_req), 32'd0);
      check_val("rst_addr", 32'(mem_addr), 32'd0);
      check_val("rst_underrun", 32'(underrun), 32'd0);
      presetn = 1'b1;
      repeat (5) @(negedge pclk);

      do_jedec("jedec");

      // Reset asserted in the middle of an ID readout
      cs_begin();
      spi_byte(8'h9F, r);
      spi_bit(1'b0, b);
      repeat (4) @(negedge pclk);
      check_val("rst_pre_miso", 32'(spi_miso), 32'(ID_STREAM[30]));
      presetn = 1'b0;
      @(negedge pclk);
      check_val("rst_mid_miso", 32'(spi_miso), 32'd0);
      check_val("rst_mid_req", 32'(mem_req), 32'd0);
      check_val("rst_mid_underrun", 32'(underrun), 32'd0);
      spi_cs  = 1'b1;
      spi_clk = 1'b0;
      repeat (4) @(negedge pclk);
      presetn = 1'b1;
      repeat (8) @(negedge pclk);
      do_jedec("jedec_after_rst");

      // Unaligned fast read with fixed words
      mem_aa[22'd0] = 32'h4433_2211;
      mem_aa[22'd1] = 32'h8877_6655;
      ack_delay = 2;
      do_read(24'h000002, 6, 0, "fr_unal");

      do_read(24'hFFFFFC, 8, 0, "wrap");

      // First fetch late at a slower SCK: only byte 0 underruns
      half_p = 8;
      next_delay = 200;
      do_read(24'h000100, 6, 1, "undr");
      half_p = 4;

      // Abort during ADDR
      addr_log.delete();
      cs_begin();
      spi_byte(8'h0B, r);
      spi_byte(8'h12, r);
      spi_bit(1'b1, b);
      spi_bit(1'b0, b);
      cs_end("abort_addr");
      check_val("abort_addr_miso", 32'(spi_miso), 32'd0);
      check_val("abort_addr_nreq", 32'(addr_log.size()), 32'd0);
      do_jedec("jedec_after_abort_addr");

      // Abort with a request still pending
      next_delay = 150;
      cs_begin();
      spi_byte(8'h0B, r);
      spi_byte(8'h00, r);
      spi_byte(8'h04, r);
      spi_byte(8'h40, r);
      spi_byte(8'h00, r);
      spi_bit(1'b0, b);
      spi_bit(1'b0, b);
      spi_bit(1'b0, b);
      check_val("abort_pend_data_miso", 32'(b), 32'd1);
      a0 = ack_cnt;
      spi_cs = 1'b1;
      repeat (8) @(negedge pclk);
      check_val("abort_pend_miso", 32'(spi_miso), 32'd0);
      check_val("abort_pend_req_held", 32'(mem_req), 32'd1);
      wait_mem_idle("abort_pend_mem_idle");
      check_val("abort_pend_ack_before_drop", 32'(ack_cnt - a0), 32'd1);
      repeat (4) @(negedge pclk);
      do_jedec("jedec_after_abort_pend");
      do_read(24'h001041, 5, 0, "read_after_abort");

      // Randomised transactions
      for (int it = 0; it < 10; it++) begin
         ack_delay = int'($urandom_range(1, 20));
         kind = int'($urandom_range(0, 2));
         if (kind == 0) begin
            do_jedec($sformatf("rnd%0d_jedec", it));
         end else if (kind == 1) begin
            do_read(24'($urandom), int'($urandom_range(1, 9)), 0, $sformatf("rnd%0d_read", it));
         end else begin
            cmd = 8'($urandom);
            if (cmd == 8'h0B || cmd == 8'h9F) cmd = 8'h03;
            cs_begin();
            spi_byte(cmd, r);
            for (int i = 0; i < 2; i++) begin
               spi_byte(8'($urandom), r);
               check_val($sformatf("rnd%0d_ign%0d", it, i), 32'(r), 32'd0);
            end
            cs_end($sformatf("rnd%0d_ign", it));
         end
      end

      check_val("req_hold_errs", 32'(hold_err), 32'd0);
      check_val("req_drop_errs", 32'(drop_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
